// File: rtl/ej32_rs_ctl.sv
// rtl/ej32_rs_ctl.sv - eJ32 return-stack controller: top-of-stack register over a single-port sync-read RAM
module ej32_rs_ctl #(
  parameter int RS_DEPTH = 32,
  parameter int DSZ      = 32,
  parameter int SSZ      = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           op_valid,
  input  logic [1:0]     op,
  input  logic [DSZ-1:0] wd,
  input  logic           pick_valid,
  input  logic [SSZ-1:0] pick_idx,
  output logic           rdy,
  output logic [DSZ-1:0] r,
  output logic [SSZ:0]   depth,
  output logic           empty,
  output logic           full,
  output logic [DSZ-1:0] pick_data,
  output logic           pick_done,
  input  logic           err_clr,
  output logic           ovf,
  output logic           unf
);

  localparam logic [1:0]   OP_NOP    = 2'd0;
  localparam logic [1:0]   OP_PUSH   = 2'd1;
  localparam logic [1:0]   OP_POP    = 2'd2;
  localparam logic [1:0]   OP_MOVE   = 2'd3;
  localparam logic [SSZ:0] DEPTH_MAX = (SSZ+1)'(RS_DEPTH);
  localparam logic [SSZ:0] ONE       = (SSZ+1)'(1);
  localparam logic [SSZ:0] TWO       = (SSZ+1)'(2);

  typedef enum logic [1:0] {S_IDLE, S_REFILL, S_PICK} state_t;
  typedef enum logic [1:0] {PS_TOP, PS_RAM, PS_ZERO} pick_src_t;

  state_t    state, state_nxt;
  pick_src_t pick_src, pick_src_nxt;

  logic [DSZ-1:0] r_nxt, pick_data_nxt;
  logic [SSZ:0]   depth_nxt;
  logic           pick_done_nxt;
  logic           ovf_set, unf_set;

  logic           ram_we, ram_re;
  logic [SSZ-1:0] ram_addr;
  logic [DSZ-1:0] ram_q;
  logic [DSZ-1:0] mem [RS_DEPTH-1];

  logic [SSZ:0] depth_m1, depth_m2, pick_pos;
  logic         op_take;

  assign depth_m1 = depth - ONE;
  assign depth_m2 = depth - TWO;
  assign pick_pos = depth_m1 - {1'b0, pick_idx};
  assign op_take  = op_valid && (op != OP_NOP);

  assign rdy   = (state == S_IDLE);
  assign empty = (depth == '0);
  assign full  = (depth == DEPTH_MAX);

  always_comb begin
    state_nxt     = state;
    pick_src_nxt  = pick_src;
    r_nxt         = r;
    depth_nxt     = depth;
    pick_data_nxt = pick_data;
    pick_done_nxt = 1'b0;
    ovf_set       = 1'b0;
    unf_set       = 1'b0;
    ram_we        = 1'b0;
    ram_re        = 1'b0;
    ram_addr      = '0;

    case (state)
      S_IDLE: begin
        if (op_take) begin
          case (op)
            OP_PUSH: begin
              if (full) begin
                ovf_set = 1'b1;
              end else begin
                // Spill the current top into RAM before it is replaced.
                if (!empty) begin
                  ram_we   = 1'b1;
                  ram_addr = depth_m1[SSZ-1:0];
                end
                r_nxt     = wd;
                depth_nxt = depth + ONE;
              end
            end
            OP_MOVE: begin
              if (empty) unf_set = 1'b1;
              else       r_nxt   = wd;
            end
            OP_POP: begin
              if (empty) begin
                unf_set = 1'b1;
              end else if (depth == ONE) begin
                r_nxt     = '0;
                depth_nxt = '0;
              end else begin
                ram_re    = 1'b1;
                ram_addr  = depth_m2[SSZ-1:0];
                depth_nxt = depth_m1;
                state_nxt = S_REFILL;
              end
            end
            default: ;
          endcase
        end else if (pick_valid) begin
          state_nxt = S_PICK;
          if ({1'b0, pick_idx} >= depth) begin
            unf_set      = 1'b1;
            pick_src_nxt = PS_ZERO;
          end else if (pick_idx == '0) begin
            pick_src_nxt = PS_TOP;
          end else begin
            ram_re       = 1'b1;
            ram_addr     = pick_pos[SSZ-1:0];
            pick_src_nxt = PS_RAM;
          end
        end
      end
      S_REFILL: begin
        r_nxt     = ram_q;
        state_nxt = S_IDLE;
      end
      S_PICK: begin
        case (pick_src)
          PS_TOP:  pick_data_nxt = r;
          PS_RAM:  pick_data_nxt = ram_q;
          default: pick_data_nxt = '0;
        endcase
        pick_done_nxt = 1'b1;
        state_nxt     = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r         <= '0;
      depth     <= '0;
      pick_data <= '0;
      pick_done <= 1'b0;
      pick_src  <= PS_ZERO;
      ovf       <= 1'b0;
      unf       <= 1'b0;
    end else begin
      r         <= r_nxt;
      depth     <= depth_nxt;
      pick_data <= pick_data_nxt;
      pick_done <= pick_done_nxt;
      pick_src  <= pick_src_nxt;
      // A new error in the same cycle as err_clr keeps the flag set.
      ovf       <= (ovf & ~err_clr) | ovf_set;
      unf       <= (unf & ~err_clr) | unf_set;
    end
  end

  // Single port: a write and a read are never requested together.
  always_ff @(posedge clk) begin
    if (ram_we)      mem[ram_addr] <= r;
    else if (ram_re) ram_q         <= mem[ram_addr];
  end

endmodule

// File: tb/tb_ej32_rs_ctl.sv
// tb/tb_ej32_rs_ctl.sv - self-checking bench for ej32_rs_ctl against a queue-based stack model
module tb_ej32_rs_ctl;

  localparam int RS_DEPTH = 32;
  localparam int DSZ      = 32;
  localparam int SSZ      = 5;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           op_valid = 1'b0;
  logic [1:0]     op = 2'd0;
  logic [DSZ-1:0] wd = '0;
  logic           pick_valid = 1'b0;
  logic [SSZ-1:0] pick_idx = '0;
  logic           err_clr = 1'b0;
  logic           rdy, empty, full, pick_done, ovf, unf;
  logic [DSZ-1:0] r, pick_data;
  logic [SSZ:0]   depth;

  ej32_rs_ctl #(.RS_DEPTH(RS_DEPTH), .DSZ(DSZ), .SSZ(SSZ)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .wd(wd),
    .pick_valid(pick_valid), .pick_idx(pick_idx), .rdy(rdy), .r(r),
    .depth(depth), .empty(empty), .full(full), .pick_data(pick_data),
    .pick_done(pick_done), .err_clr(err_clr), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  int unsigned q[$];
  bit m_ovf = 0;
  bit m_unf = 0;

  function automatic logic [63:0] exp_top();
    return (q.size() > 0) ? 64'(q[q.size()-1]) : 64'd0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".r"}, 64'(r), exp_top());
    chk({tag, ".depth"}, 64'(depth), 64'(q.size()));
    chk({tag, ".empty"}, 64'(empty), 64'(q.size() == 0));
    chk({tag, ".full"}, 64'(full), 64'(q.size() == RS_DEPTH));
    chk({tag, ".ovf"}, 64'(ovf), 64'(m_ovf));
    chk({tag, ".unf"}, 64'(unf), 64'(m_unf));
  endtask

  task automatic wait_rdy();
    int n = 0;
    while (!rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("wait_rdy", 64'(rdy), 64'd1);
  endtask

  function automatic void model_op(input int o, input int unsigned d);
    case (o)
      1: if (q.size() == RS_DEPTH) m_ovf = 1; else q.push_back(d);
      2: if (q.size() == 0) m_unf = 1; else void'(q.pop_back());
      3: if (q.size() == 0) m_unf = 1; else q[q.size()-1] = d;
      default: ;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic do_op(input int o, input int unsigned d);
    wait_rdy();
    op_valid = 1'b1;
    op       = 2'(o);
    wd       = d;
    @(negedge clk);
    op_valid = 1'b0;
    model_op(o, d);
  endtask

  task automatic do_pick(input int idx, input string tag);
    logic [63:0] exp_d;
    wait_rdy();
    exp_d = (idx < q.size()) ? 64'(q[q.size()-1-idx]) : 64'd0;
    if (idx >= q.size()) m_unf = 1;
    pick_valid = 1'b1;
    pick_idx   = SSZ'(idx);
    @(negedge clk);
    pick_valid = 1'b0;
    chk({tag, ".rdy_low"}, 64'(rdy), 64'd0);
    chk({tag, ".done_early"}, 64'(pick_done), 64'd0);
    @(negedge clk);
    chk({tag, ".done"}, 64'(pick_done), 64'd1);
    chk({tag, ".data"}, 64'(pick_data), exp_d);
    chk({tag, ".unf"}, 64'(unf), 64'(m_unf));
    @(negedge clk);
    chk({tag, ".done_pulse"}, 64'(pick_done), 64'd0);
  endtask

  task automatic do_clr();
    wait_rdy();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    m_ovf = 0;
    m_unf = 0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_all("reset");
    chk("reset.rdy", 64'(rdy), 64'd1);
    chk("reset.pick_done", 64'(pick_done), 64'd0);
    chk("reset.pick_data", 64'(pick_data), 64'd0);

    // Back-to-back pushes, rdy never drops.
    do_op(1, 32'h11); chk("push1.rdy", 64'(rdy), 64'd1);
    do_op(1, 32'h22); chk("push2.rdy", 64'(rdy), 64'd1);
    do_op(1, 32'h33); chk("push3.rdy", 64'(rdy), 64'd1);
    check_all("push3");

    // POP with refill: depth first, r two cycles after accept.
    wait_rdy();
    op_valid = 1'b1; op = 2'd2;
    @(negedge clk);
    op_valid = 1'b0;
    chk("pop1.rdy_low", 64'(rdy), 64'd0);
    chk("pop1.depth_early", 64'(depth), 64'd2);
    chk("pop1.r_old", 64'(r), 64'h33);
    @(negedge clk);
    model_op(2, 0);
    chk("pop1.rdy_back", 64'(rdy), 64'd1);
    check_all("pop1");
    do_op(2, 0);
    wait_rdy();
    check_all("pop2");
    do_op(2, 0);
    chk("pop3.rdy", 64'(rdy), 64'd1);
    check_all("pop3");

    // Fill to full, overflow, set-wins, clear.
    for (int i = 1; i <= RS_DEPTH; i++) do_op(1, i);
    check_all("fill");
    do_op(1, 32'h99);
    check_all("ovf");
    wait_rdy();
    err_clr = 1'b1; op_valid = 1'b1; op = 2'd1; wd = 32'h77;
    @(negedge clk);
    err_clr = 1'b0; op_valid = 1'b0;
    chk("ovf.set_wins", 64'(ovf), 64'd1);
    do_clr();
    check_all("ovf_clr");
    for (int i = 0; i < RS_DEPTH; i++) begin
      do_op(2, 0);
      wait_rdy();
      chk("drain.r", 64'(r), exp_top());
    end
    check_all("drain");
    do_op(2, 0);
    check_all("pop_empty_unf");
    do_clr();

    // PICK at top, deep, and past the bottom.
    do_op(1, 32'hA); do_op(1, 32'hB); do_op(1, 32'hC);
    do_pick(0, "pick0");
    do_pick(2, "pick2");
    do_pick(3, "pick3");
    do_clr();
    check_all("pick_clr");

    // PUSH and PICK in the same cycle: PUSH first, held PICK sees the new top.
    wait_rdy();
    op_valid = 1'b1; op = 2'd1; wd = 32'h5;
    pick_valid = 1'b1; pick_idx = '0;
    @(negedge clk);
    op_valid = 1'b0;
    model_op(1, 32'h5);
    chk("prio.pick_not_taken", 64'(rdy), 64'd1);
    check_all("prio.push");
    @(negedge clk);
    pick_valid = 1'b0;
    chk("prio.rdy_low", 64'(rdy), 64'd0);
    @(negedge clk);
    chk("prio.done", 64'(pick_done), 64'd1);
    chk("prio.data", 64'(pick_data), 64'h5);

    // Reset in the REFILL cycle.
    do_op(2, 0);
    wait_rdy();
    check_all("pre_rst");
    op_valid = 1'b1; op = 2'd2;
    @(negedge clk);
    op_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q.delete(); m_ovf = 0; m_unf = 0;
    chk("rst_refill.rdy", 64'(rdy), 64'd1);
    check_all("rst_refill");
    @(negedge clk);
    chk("rst_refill.no_stale_r", 64'(r), 64'd0);
    chk("rst_refill.no_done", 64'(pick_done), 64'd0);

    // Randomised operations against the model.
    for (int it = 0; it < 400; it++) begin
      int act;
      act = int'($urandom_range(0, 11));
      if (act <= 4)       do_op(1, $urandom);
      else if (act <= 6)  do_op(2, 0);
      else if (act == 7)  do_op(3, $urandom);
      else if (act <= 9) begin
        int lim;
        lim = (q.size() + 1 > RS_DEPTH - 1) ? RS_DEPTH - 1 : q.size() + 1;
        do_pick(int'($urandom_range(0, lim)), "rnd_pick");
      end
      else if (act == 10) do_op(0, $urandom);
      else                do_clr();
      wait_rdy();
      check_all("rnd");
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
